// File: rtl/ppu_oam_dma_if.sv
// Bus bundle between the CPU core, the sprite DMA engine and the arbiter.
// master: the DMA engine.  slave: the system side (CPU core, arbiter and bus).
interface ppu_oam_dma_if;
  logic        cpu_tick_i;
  logic [15:0] cpu_addr_i;
  logic [7:0]  cpu_data_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic        cpu_halt_o;
  logic        dma_active_o;
  logic [15:0] dma_addr_o;
  logic [7:0]  dma_data_o;
  logic        dma_we_o;
  logic        dma_ce_o;
  logic [7:0]  dma_data_i;

  modport master (
    input  cpu_tick_i, cpu_addr_i, cpu_data_i, cpu_ce_i, cpu_we_i, dma_data_i,
    output cpu_halt_o, dma_active_o, dma_addr_o, dma_data_o, dma_we_o, dma_ce_o
  );

  modport slave (
    output cpu_tick_i, cpu_addr_i, cpu_data_i, cpu_ce_i, cpu_we_i, dma_data_i,
    input  cpu_halt_o, dma_active_o, dma_addr_o, dma_data_o, dma_we_o, dma_ce_o
  );
endinterface

// File: rtl/ppu_oam_dma.sv
// Sprite OAM DMA engine: snoops the CPU write to the trigger register, halts
// the CPU, then copies 256 bytes of page $XX00-$XXFF into OAMDATA by mastering
// the bus on alternating get (read) / put (write) CPU cycles.
// Optional feature macro: OAM_DMA_ABORT_EN (adds the abort_i port).
module ppu_oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef OAM_DMA_ABORT_EN
  input  logic           abort_i,
`endif
  ppu_oam_dma_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_HALT, S_READ, S_WRITE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        get_q, get_d;
  logic        halt_q, halt_d;
  logic        active_q, active_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        abort;
  logic        trigger;

`ifdef OAM_DMA_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign trigger = bus.cpu_ce_i & bus.cpu_we_i & (bus.cpu_addr_i == DMA_REG_ADDR);

  // Next-state logic: everything advances only on the end-of-CPU-cycle tick.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    get_d   = get_q;
    if (bus.cpu_tick_i) begin
      get_d = ~get_q;
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            page_d  = bus.cpu_data_i;
            idx_d   = 8'h00;
            state_d = S_HALT;
          end
        end
        S_HALT: begin
          // A CPU write cycle cannot be halted; wait for the first read cycle.
          if (abort)                state_d = S_IDLE;
          else if (!bus.cpu_we_i)   state_d = S_READ;
        end
        S_READ: begin
          // Only a get cycle can read; a put cycle here is a pure alignment cycle.
          if (abort) begin
            state_d = S_IDLE;
          end else if (get_q) begin
            byte_d  = bus.dma_data_i;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          idx_d   = idx_q + 8'd1;
          state_d = ((idx_q == 8'hFF) || abort) ? S_IDLE : S_READ;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Bus-facing outputs are derived from the state being entered so they are
    // stable for the whole CPU cycle that follows.
    halt_d   = (state_d != S_IDLE);
    active_d = (state_d == S_READ) || (state_d == S_WRITE);
    we_d     = (state_d == S_WRITE);
    if (state_d == S_READ)       addr_d = {page_d, idx_d};
    else if (state_d == S_WRITE) addr_d = OAMDATA_ADDR;
    else                         addr_d = 16'h0000;
  end

  // State and registered output flops; reset releases the CPU immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      byte_q   <= 8'h00;
      get_q    <= 1'b0;
      halt_q   <= 1'b0;
      active_q <= 1'b0;
      addr_q   <= 16'h0000;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      get_q    <= get_d;
      halt_q   <= halt_d;
      active_q <= active_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
    end
  end

  assign bus.cpu_halt_o   = halt_q;
  assign bus.dma_active_o = active_q;
  assign bus.dma_addr_o   = addr_q;
  assign bus.dma_data_o   = byte_q;
  assign bus.dma_we_o     = we_q;
  // The strobe is the tick itself, gated to real bus accesses.
  assign bus.dma_ce_o     = bus.cpu_tick_i &
                            (((state_q == S_READ) & get_q) | (state_q == S_WRITE));

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Self-checking bench for ppu_oam_dma: table of idle-traffic vectors, directed
// transfers (aligned, misaligned, CPU writes in halt, reset, abort) and random
// transfers checked against a cycle-count/byte-sequence reference model.
module tb_ppu_oam_dma;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ppu_oam_dma_if bus();
`ifdef OAM_DMA_ABORT_EN
  logic abort_i = 1'b0;
`endif

  ppu_oam_dma dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef OAM_DMA_ABORT_EN
    .abort_i (abort_i),
`endif
    .bus     (bus)
  );

  // Source memory contents: page 02 holds i^5A, other pages a page-dependent twist.
  function automatic logic [7:0] src_byte(input logic [7:0] page, input logic [7:0] idx);
    return idx ^ 8'h5A ^ (page - 8'h02);
  endfunction

  // Bus slave: returns memory contents on DMA read cycles.
  always_comb begin
    bus.dma_data_i = 8'h00;
    if (bus.dma_active_o && !bus.dma_we_o)
      bus.dma_data_i = src_byte(bus.dma_addr_o[15:8], bus.dma_addr_o[7:0]);
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int abort_idx = -1;
  logic o_halt, o_active, o_ce, o_we, post_halt, did_abort;
  logic [15:0] o_addr;
  logic [7:0]  o_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // One CPU cycle = 3 clks; outputs sampled just before the tick edge.
  task automatic cpu_cycle(input logic ce, input logic we, input logic [15:0] addr,
                           input logic [7:0] data);
    @(negedge clk);
    bus.cpu_ce_i   = ce;
    bus.cpu_we_i   = we;
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = data;
    bus.cpu_tick_i = 1'b0;
    did_abort      = 1'b0;
`ifdef OAM_DMA_ABORT_EN
    abort_i = 1'b0;
    if (abort_idx >= 0 && bus.dma_active_o && !bus.dma_we_o &&
        bus.dma_addr_o[7:0] == 8'(abort_idx)) begin
      abort_i   = 1'b1;
      did_abort = 1'b1;
    end
`endif
    @(negedge clk);
    @(negedge clk);
    bus.cpu_tick_i = 1'b1;
    #2;
    o_halt   = bus.cpu_halt_o;
    o_active = bus.dma_active_o;
    o_ce     = bus.dma_ce_o;
    o_we     = bus.dma_we_o;
    o_addr   = bus.dma_addr_o;
    o_data   = bus.dma_data_o;
    @(posedge clk);
    #1;
    post_halt      = bus.cpu_halt_o;
    bus.cpu_tick_i = 1'b0;
`ifdef OAM_DMA_ABORT_EN
    abort_i = 1'b0;
`endif
    cyc++;
  endtask

  // Random non-trigger CPU traffic; the engine must stay idle throughout.
  task automatic random_idle(input int n);
    int bad = 0;
    logic [15:0] a;
    logic ce, we;
    for (int i = 0; i < n; i++) begin
      a  = 16'($urandom);
      ce = 1'($urandom);
      we = 1'($urandom);
      if (a == 16'h4014) a = 16'h4015;
      cpu_cycle(ce, we, a, 8'($urandom));
      if (o_halt || o_active || o_ce || post_halt) bad++;
    end
    check("random idle traffic busy", 32'(bad), 32'd0);
  endtask

  // Pad to the requested parity, trigger, observe the whole transfer, compare
  // against counts and byte sequence computed from the transfer rules.
  task automatic run_transfer(input string name, input logic [7:0] page, input bit aligned,
                              input int w, input int ab);
    int t, halt_cnt, align_cnt, bus_in_halt, first_wr, exp_writes, exp_halt, exp_reads;
    bit seen, done;
    logic [7:0]  wq[$];
    logic [15:0] rq[$];
    halt_cnt = 0; align_cnt = 0; bus_in_halt = 0; first_wr = -1; seen = 0; done = 0;
    abort_idx = ab;
    while (((cyc + w + 2) & 1) != (aligned ? 1 : 0))
      cpu_cycle(1'b0, 1'b0, 16'h0000, 8'h00);
    t = cyc;
    cpu_cycle(1'b1, 1'b1, 16'h4014, page);
    check({name, " halt after trigger"}, 32'(post_halt), 32'd1);
    for (int n = 0; n < 700 && !done; n++) begin
      if (n < w) cpu_cycle(1'b1, 1'b1, 16'h01FD, 8'($urandom));
      else       cpu_cycle(1'b1, 1'b0, 16'(32'h8000 + n), 8'h00);
      if (o_halt) halt_cnt++;
      if (o_halt && !o_active && (o_ce || o_we)) bus_in_halt++;
      if (o_active && !o_we && !o_ce) align_cnt++;
      if (o_ce && !o_we) rq.push_back(o_addr);
      if (o_ce && o_we && o_addr == 16'h2004) begin
        if (first_wr < 0) first_wr = cyc - 1 - t;
        wq.push_back(o_data);
      end
      if (did_abort) check({name, " halt released after abort"}, 32'(post_halt), 32'd0);
      if (o_halt) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    abort_idx = -1;

    exp_writes = (ab >= 0) ? ab : 256;
    exp_reads  = (ab >= 0) ? ab + 1 : 256;
    exp_halt   = 1 + w + (aligned ? 0 : 1) + 2 * exp_writes + ((ab >= 0) ? 1 : 0);
    check({name, " completed in bound"}, 32'(done), 32'd1);
    check({name, " halt length"}, 32'(halt_cnt), 32'(exp_halt));
    check({name, " alignment cycles"}, 32'(align_cnt), aligned ? 32'd0 : 32'd1);
    check({name, " bus access in halt"}, 32'(bus_in_halt), 32'd0);
    check({name, " first write latency"}, 32'(first_wr), 32'((aligned ? 3 : 4) + w));
    check({name, " write count"}, 32'(wq.size()), 32'(exp_writes));
    check({name, " read count"}, 32'(rq.size()), 32'(exp_reads));
    for (int j = 0; j < wq.size() && j < exp_writes; j++)
      check({name, " oam data"}, 32'(wq[j]), 32'(src_byte(page, 8'(j))));
    for (int j = 0; j < rq.size() && j < exp_reads; j++)
      check({name, " read addr"}, 32'(rq[j]), 32'({page, 8'(j)}));
    $display("xfer %s page=%02h aligned=%0d halt_writes=%0d halt=%0d writes=%0d latency=%0d",
             name, page, aligned, w, halt_cnt, wq.size(), first_wr);
  endtask

  typedef struct {
    logic        ce;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_halt;
    logic        exp_active;
  } vec_t;

  vec_t vecs[7];
  int   nwr;
  logic [7:0] rpage;

  initial begin
    // Non-trigger traffic: nothing may start.
    vecs[0] = '{1'b1, 1'b1, 16'h4015, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h2014, 8'h02, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h4014, 8'h02, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'h4014, 8'h02, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 16'h4013, 8'h07, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 16'hC014, 8'h03, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'h0014, 8'hFF, 1'b0, 1'b0};

    bus.cpu_tick_i = 1'b0;
    bus.cpu_addr_i = 16'h0000;
    bus.cpu_data_i = 8'h00;
    bus.cpu_ce_i   = 1'b0;
    bus.cpu_we_i   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset cpu_halt_o", 32'(bus.cpu_halt_o), 32'd0);
    check("reset dma_active_o", 32'(bus.dma_active_o), 32'd0);
    check("reset dma_addr_o", 32'(bus.dma_addr_o), 32'd0);
    check("reset dma_data_o", 32'(bus.dma_data_o), 32'd0);
    check("reset dma_we_o", 32'(bus.dma_we_o), 32'd0);
    check("reset dma_ce_o", 32'(bus.dma_ce_o), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;

    foreach (vecs[i]) begin
      cpu_cycle(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].data);
      check($sformatf("vector %0d halt", i), 32'(post_halt), 32'(vecs[i].exp_halt));
      check($sformatf("vector %0d active", i), 32'(bus.dma_active_o), 32'(vecs[i].exp_active));
      $display("vec %0d addr=%04h ce=%0d we=%0d halt=%0d", i, vecs[i].addr, vecs[i].ce,
               vecs[i].we, post_halt);
    end

    run_transfer("aligned", 8'h02, 1'b1, 0, -1);
    run_transfer("misaligned", 8'h02, 1'b0, 0, -1);
    run_transfer("halt writes aligned", 8'h02, 1'b1, 2, -1);
    run_transfer("halt writes misaligned", 8'h02, 1'b0, 2, -1);
    run_transfer("ppu page", 8'h20, 1'b1, 1, -1);

    // Reset mid-transfer after 100 bytes.
    while ((cyc & 1) != 1) cpu_cycle(1'b0, 1'b0, 16'h0000, 8'h00);
    cpu_cycle(1'b1, 1'b1, 16'h4014, 8'h04);
    nwr = 0;
    for (int n = 0; n < 400 && nwr < 100; n++) begin
      cpu_cycle(1'b1, 1'b0, 16'h8000, 8'h00);
      if (o_ce && o_we) nwr++;
    end
    check("writes before reset", 32'(nwr), 32'd100);
    check("busy before reset", 32'(bus.cpu_halt_o), 32'd1);
    @(negedge clk);
    bus.cpu_tick_i = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("async reset cpu_halt_o", 32'(bus.cpu_halt_o), 32'd0);
    check("async reset dma_active_o", 32'(bus.dma_active_o), 32'd0);
    check("async reset dma_addr_o", 32'(bus.dma_addr_o), 32'd0);
    check("async reset dma_data_o", 32'(bus.dma_data_o), 32'd0);
    check("async reset dma_we_o", 32'(bus.dma_we_o), 32'd0);
    check("async reset dma_ce_o", 32'(bus.dma_ce_o), 32'd0);
    bus.cpu_tick_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    $display("xfer reset after %0d bytes", nwr);
    run_transfer("after reset", 8'h05, 1'b0, 0, -1);

`ifdef OAM_DMA_ABORT_EN
    run_transfer("abort", 8'h02, 1'b1, 0, 16);
    random_idle(3);
`endif

    for (int r = 0; r < 4; r++) begin
      random_idle($urandom_range(1, 6));
      rpage = 8'($urandom);
      run_transfer($sformatf("random %0d", r), rpage, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ppu_oam_dma.md
# ppu_oam_dma

Sprite DMA initiator for the CPU-side system bus. It snoops CPU writes to $4014, halts the CPU, then masters the bus to copy 256 bytes from CPU page $XX00–$XXFF into PPU OAMDATA ($2004). The block sits between the CPU core and the bus arbiter. While it owns the bus, its address, data and strobe outputs replace the CPU's, so every byte reaches the PPU register file as an ordinary $2004 write.

## Interface
Parameters:
- `DMA_REG_ADDR`, default 16'h4014: trigger register address.
- `OAMDATA_ADDR`, default 16'h2004: destination register address.

Ports:
- `clk`  in  1: system (PPU-rate) clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `cpu_tick_i`  in  1: one-clk pulse marking the end of each CPU cycle; all state advances only on ticks.
- `cpu_addr_i`  in  16: CPU address, current cycle.
- `cpu_data_i`  in  8: CPU write data.
- `cpu_ce_i`  in  1: CPU access valid this cycle.
- `cpu_we_i`  in  1: CPU access is a write.
- `cpu_halt_o`  out  1: RDY-low request to CPU core.
- `dma_active_o`  out  1: arbiter select; 1 = bus driven by this block.
- `dma_addr_o`  out  16: bus address while active.
- `dma_data_o`  out  8: bus write data.
- `dma_we_o`  out  1: bus write enable.
- `dma_ce_o`  out  1: bus access strobe, equal to `cpu_tick_i` on access cycles.
- `dma_data_i`  in  8: bus read data, valid at tick of read cycle.
- `abort_i`  in  1: only with OAM_DMA_ABORT_EN.

## Operation
- Parity flop `get_q` toggles every tick; 1 means the current CPU cycle is a get (read) cycle. It resets to 0.
- States: IDLE, HALT, READ, WRITE.
- IDLE: a tick with `cpu_ce_i & cpu_we_i & cpu_addr_i==DMA_REG_ADDR` latches `page_q <= cpu_data_i`, clears `idx_q`, and moves to HALT.
- HALT: `cpu_halt_o`=1. On a tick with `cpu_we_i`=1 the CPU is not yet stopped and the block stays in HALT; writes cannot be halted. On a tick with `cpu_we_i`=0 the block moves to READ. That cycle is the dummy halt cycle.
- READ: `dma_active_o`=1, `dma_addr_o={page_q,idx_q}`, `dma_we_o`=0.
  - Tick with `get_q`=1: capture `byte_q <= dma_data_i`, then move to WRITE.
  - Tick with `get_q`=0: alignment cycle. `dma_ce_o` stays 0 and the block remains in READ.
- WRITE (always a put cycle): `dma_addr_o`=OAMDATA_ADDR, `dma_data_o=byte_q`, `dma_we_o`=1.
  - On the tick, `idx_q` increments (8-bit wrap).
  - If `idx_q` was 8'hFF, go to IDLE; otherwise go to READ.
- Total halt length: 513 CPU cycles if the first READ lands on a get cycle, 514 otherwise. Each extra CPU write cycle seen in HALT adds one.
- A trigger write while not IDLE is impossible because the CPU is halted. It is ignored if it appears.
- Writes to any address other than DMA_REG_ADDR have no effect.
- The source page is any value 00–FF. Page $20–$3F reads PPU registers through the bus; this is legal and not filtered.

## Timing
- Reset values: state IDLE; `cpu_halt_o`, `dma_active_o`, `dma_we_o`, `dma_ce_o` = 0; `dma_addr_o`, `dma_data_o`, `page_q`, `idx_q`, `byte_q`, `get_q` = 0.
- Reset mid-transfer: all outputs drop asynchronously and the CPU is released. The transfer is not resumed.
- Registered outputs change on the clk of the tick that enters a state and are held stable for the whole CPU cycle:
  - `cpu_halt_o`, `dma_active_o`, `dma_addr_o`, `dma_data_o`, `dma_we_o`.
  - `cpu_halt_o` is high from the tick after the trigger until the tick of the final WRITE; it is low on the following clk.
- `dma_active_o` is high in READ and WRITE only, not in HALT.
- `dma_ce_o` is combinational: `cpu_tick_i & ((READ & get_q) | WRITE)`.
- Read data is sampled on the same clk as the `dma_ce_o` pulse.
- Latency: from trigger tick to the first OAM write tick is 3 CPU cycles when aligned, 4 when not.

## Configuration
- `OAM_DMA_ABORT_EN`: when defined, the `abort_i` port exists. An `abort_i`=1 sampled on a tick in HALT or READ returns the block to IDLE at that tick; the pending byte is not written. In WRITE, the current write completes and the block then goes to IDLE.
- When not defined, the port is absent and every started transfer runs all 256 bytes.

## Test plan
- Aligned trigger: write $02 to $4014 so that the first READ tick has `get_q`=1, with RAM $0200+i = i^8'h5A. Required: 256 writes to $2004 with data i^5A in order, and `cpu_halt_o` high for exactly 513 ticks.
- Misaligned trigger: same setup with the opposite parity. Required: one alignment cycle with no `dma_ce_o`, then 514 halted ticks and identical data.
- CPU write in HALT: hold `cpu_we_i`=1 for 2 ticks after the trigger. Required: HALT lasts 3 ticks, total halt 515/516 ticks, no bus access during HALT.
- Non-trigger traffic: writes to $4015 and $2014, and a read of $4014. Required: state stays IDLE and `cpu_halt_o` stays 0.
- Reset mid-transfer: assert `rst_n`=0 after 100 bytes. Required: all outputs 0 immediately. A new trigger afterwards starts again from idx 0.
- OAM_DMA_ABORT_EN: pulse `abort_i` in READ at idx 8'h10. Required: exactly 16 writes to $2004, then IDLE, and halt released on the next clk.
